// File: rtl/display_scan_sched.sv
// Scan scheduler for a 3-digit 7-segment display: samples a binary count per frame,
// converts it to BCD with shift-add-3, and rotates digit selects with blanking dead-time.
//
// Slot phase (decoded from slot_cnt):
//   state   | meaning
//   BLANK   | slot_cnt < BLANK_CYCLES, all digit selects and segments off
//   ON      | digit `dig` selected and driven with its pattern
// Converter FSM:
//   state   | meaning
//   C_IDLE  | wait for frame start, then latch count and clear BCD accumulator
//   C_SHIFT | 16 add-3/shift iterations over {bcd,bin}
//   C_DONE  | publish low three BCD nibbles to the shadow register
module display_scan_sched #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 16,
  parameter bit LZ_BLANK     = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] count,
  output logic [2:0]  seg,
  output logic [6:0]  codeout,
  output logic        frame_tick
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] SLOT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

  typedef enum logic [1:0] {C_IDLE, C_SHIFT, C_DONE} conv_state_t;

  logic [CW-1:0] slot_cnt;
  logic [1:0]    dig;
  logic          frame_start;
  logic [11:0]   disp;
  logic [11:0]   shadow;
  logic [3:0]    nib;
  logic          nib_blank;
  logic [6:0]    pat;

  conv_state_t   cst;
  logic [19:0]   bcd;
  logic [19:0]   bcd_adj;
  logic [15:0]   bin;
  logic [3:0]    iter;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  assign frame_start = (slot_cnt == '0) && (dig == 2'd0);

  always_comb begin
    nib       = disp[3:0];
    nib_blank = 1'b0;
    if (dig == 2'd1) begin
      nib       = disp[7:4];
      nib_blank = LZ_BLANK && (disp[11:8] == 4'd0) && (disp[7:4] == 4'd0);
    end else if (dig == 2'd2) begin
      nib       = disp[11:8];
      nib_blank = LZ_BLANK && (disp[11:8] == 4'd0);
    end
    pat = nib_blank ? 7'h00 : seg7(nib);
  end

  // Scan timing, output registers and the frame-synchronous display copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt   <= '0;
      dig        <= 2'd0;
      disp       <= '0;
      seg        <= 3'b000;
      codeout    <= 7'h00;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_start;
      if (frame_start) disp <= shadow;
      if (slot_cnt < BLANK_END) begin
        seg     <= 3'b000;
        codeout <= 7'h00;
      end else begin
        seg     <= 3'b001 << dig;
        codeout <= pat;
      end
      if (slot_cnt == SLOT_LAST) begin
        slot_cnt <= '0;
        dig      <= (dig == 2'd2) ? 2'd0 : dig + 2'd1;
      end else begin
        slot_cnt <= slot_cnt + CW'(1);
      end
    end
  end

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 5; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // Upper two BCD nibbles are only scratch; the display keeps count mod 1000.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cst    <= C_IDLE;
      bcd    <= '0;
      bin    <= '0;
      iter   <= '0;
      shadow <= '0;
    end else begin
      case (cst)
        C_IDLE: begin
          if (frame_start) begin
            bin  <= count;
            bcd  <= '0;
            iter <= '0;
            cst  <= C_SHIFT;
          end
        end
        C_SHIFT: begin
          {bcd, bin} <= {bcd_adj, bin} << 1;
          iter       <= iter + 4'd1;
          if (iter == 4'd15) cst <= C_DONE;
        end
        C_DONE: begin
          shadow <= bcd[11:0];
          cst    <= C_IDLE;
        end
        default: cst <= C_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_display_scan_sched.sv
// Directed bench for display_scan_sched with SCAN_DIV=32, BLANK_CYCLES=4, LZ_BLANK=1.
module tb_display_scan_sched;

  localparam int SD = 32;
  localparam int BC = 4;
  localparam int FR = 3 * SD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] count = 16'd0;
  logic [2:0]  seg;
  logic [6:0]  codeout;
  logic        frame_tick;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [15:0] cnt;
    logic [6:0]  d0;
    logic [6:0]  d1;
    logic [6:0]  d2;
  } vec_t;

  vec_t vecs[10];
  logic [6:0] p0, p1, p2;

  display_scan_sched #(.SCAN_DIV(SD), .BLANK_CYCLES(BC), .LZ_BLANK(1'b1)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .count(count),
    .seg(seg),
    .codeout(codeout),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Checks one full frame, starting from the negedge just before the frame-start edge.
  task automatic check_frame(input logic [6:0] e0, input logic [6:0] e1, input logic [6:0] e2,
                             input int chg_at, input logic [15:0] chg_val, input string tag);
    logic [6:0]  ed;
    logic [2:0]  es;
    logic [6:0]  ec;
    for (int r = 0; r < FR; r++) begin
      @(posedge clk);
      @(negedge clk);
      ed = (r / SD == 0) ? e0 : (r / SD == 1) ? e1 : e2;
      if ((r % SD) < BC) begin
        es = 3'b000;
        ec = 7'h00;
      end else begin
        es = 3'(1 << (r / SD));
        ec = ed;
      end
      check($sformatf("%s r=%0d {tick,seg,code}", tag, r),
            {21'd0, frame_tick, seg, codeout},
            {21'd0, (r == 0), es, ec});
      if (r == chg_at) count = chg_val;
    end
  endtask

  initial begin
    vecs[0] = '{16'd123,   7'h4F, 7'h5B, 7'h06};
    vecs[1] = '{16'd7,     7'h07, 7'h00, 7'h00};
    vecs[2] = '{16'd105,   7'h6D, 7'h3F, 7'h06};
    vecs[3] = '{16'd1234,  7'h66, 7'h4F, 7'h5B};
    vecs[4] = '{16'd65535, 7'h6D, 7'h4F, 7'h6D};
    vecs[5] = '{16'd40,    7'h3F, 7'h66, 7'h00};
    vecs[6] = '{16'd800,   7'h3F, 7'h3F, 7'h7F};
    vecs[7] = '{16'd10,    7'h3F, 7'h06, 7'h00};
    vecs[8] = '{16'd999,   7'h6F, 7'h6F, 7'h6F};
    vecs[9] = '{16'd0,     7'h3F, 7'h00, 7'h00};

    rst_n = 1'b0;
    count = vecs[0].cnt;
    repeat (3) @(negedge clk);
    check("reset outputs", {21'd0, frame_tick, seg, codeout}, 32'd0);
    rst_n = 1'b1;

    check_frame(7'h3F, 7'h00, 7'h00, -1, 16'd0, "boot");
    check_frame(vecs[0].d0, vecs[0].d1, vecs[0].d2, -1, 16'd0, "v0");
    p0 = vecs[0].d0; p1 = vecs[0].d1; p2 = vecs[0].d2;

    for (int i = 1; i < 10; i++) begin
      count = vecs[i].cnt;
      check_frame(p0, p1, p2, -1, 16'd0, $sformatf("v%0d_old", i));
      check_frame(vecs[i].d0, vecs[i].d1, vecs[i].d2, -1, 16'd0, $sformatf("v%0d_new", i));
      p0 = vecs[i].d0; p1 = vecs[i].d1; p2 = vecs[i].d2;
    end

    // Mid-frame count change must not be seen until the following frame sample.
    count = 16'd456;
    check_frame(p0, p1, p2, 40, 16'd789, "chg_a");
    check_frame(7'h7D, 7'h6D, 7'h66, -1, 16'd0, "chg_b");
    check_frame(7'h6F, 7'h7F, 7'h07, -1, 16'd0, "chg_c");

    // Asynchronous reset in slot 1, relative cycle 10.
    count = 16'd999;
    for (int r = 0; r < SD + 10; r++) begin
      @(posedge clk);
      @(negedge clk);
    end
    @(posedge clk);
    @(negedge clk);
    check("pre-reset slot1 r10", {25'd0, seg, codeout}, {25'd0, 3'b010, 7'h7F});
    rst_n = 1'b0;
    #1;
    check("async reset clear", {21'd0, frame_tick, seg, codeout}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("held reset clear", {21'd0, frame_tick, seg, codeout}, 32'd0);
    rst_n = 1'b1;
    check_frame(7'h3F, 7'h00, 7'h00, -1, 16'd0, "rst_f0");
    check_frame(7'h6F, 7'h6F, 7'h6F, -1, 16'd0, "rst_f1");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/display_scan_sched.md
# display_scan_sched

Time-multiplexed scan scheduler for the 3-digit 7-segment display. It samples a 16-bit binary count once per frame and converts it to BCD with an iterative shift-add-3 engine. It then rotates a one-hot digit select across the three digits, with a blanking dead-time before each digit and leading-zero suppression. The block sits between the counter datapath and the board display pins, and owns both the digit-select and segment buses.

## Interface
- SCAN_DIV, 50000, clk cycles per digit slot; legal range ≥ 24.
- BLANK_CYCLES, 16, dead-time cycles at the start of each slot; legal range 1..SCAN_DIV-1.
- LZ_BLANK, 1, 1 = suppress leading zeros on digits 2 and 1.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- count  in  16  binary value to display; sampled only at frame start.
- seg  out  3  one-hot digit select, active-high; bit0 = units, bit1 = tens, bit2 = hundreds.
- codeout  out  7  segment pattern {g,f,e,d,c,b,a}, active-high.
- frame_tick  out  1  one-cycle pulse on the first cycle of each frame.

## Operation
- Slot counter slot_cnt runs 0..SCAN_DIV-1 and wraps. A digit index dig runs 0→1→2→0 and advances on each slot_cnt wrap. A frame is 3·SCAN_DIV cycles and starts where dig=0 and slot_cnt=0.
- Per-slot FSM:
  - BLANK while slot_cnt < BLANK_CYCLES: seg=000, codeout=0.
  - ON for the rest of the slot: seg = 1<<dig, codeout = pattern of display digit dig.
- Conversion FSM (IDLE→SHIFT→DONE):
  - At frame start, IDLE latches count and clears the 20-bit BCD accumulator.
  - SHIFT runs 16 iterations. Each iteration adds 3 to every BCD nibble ≥5, then shifts {bcd,bin} left by 1.
  - DONE writes the low 12 BCD bits (units, tens, hundreds) into a shadow register, then returns to IDLE.
  - Ten-thousands and thousands nibbles are discarded, so the display shows count mod 1000.
- Shadow register is copied into the display register only at the next frame start. The display never tears mid-frame.
- Leading-zero suppression (LZ_BLANK=1):
  - Digit 2 is blank (codeout=0, seg still asserted) when hundreds=0.
  - Digit 1 is blank when hundreds=0 and tens=0.
  - Digit 0 is always shown.
- Pattern map 0..9: 3F,06,5B,4F,66,6D,7D,07,7F,6F (hex). BCD values >9 cannot occur. The decoder default is 0.
- count changes between frame starts are ignored.
- Converter always completes within 17 cycles ≤ SCAN_DIV, so a conversion never overlaps the next frame start.

## Timing
- Reset (rst_n low, asynchronous):
  - seg=000, codeout=0, frame_tick=0.
  - slot_cnt=0, dig=0, converter in IDLE.
  - Shadow and display registers = 0.
- All outputs are registered. Cycle k is the k-th rising edge with rst_n high, starting at k=0.
- Frame 0 (k=0..3·SCAN_DIV-1):
  - frame_tick=1 at k=0, and count is latched at k=0.
  - Shows the reset display value: digit 0 = 3F; digits 1 and 2 blank when LZ_BLANK=1.
- Conversion latency:
  - Latch at frame-start cycle F, 16 SHIFT cycles F+1..F+16, shadow write at F+17.
  - The value is visible from frame start F+3·SCAN_DIV. Total count-to-display latency is exactly one frame.
- Within slot s (s=0,1,2) of any frame, relative cycle r:
  - r < BLANK_CYCLES: seg=000.
  - otherwise: seg one-hot for digit s.
- frame_tick is high exactly one cycle per frame, coincident with slot_cnt=0 and dig=0.
- rst_n asserted mid-slot or mid-conversion clears all outputs immediately and discards the partial conversion. After release, operation restarts at cycle 0 with display value 0.

## Test plan
All scenarios use SCAN_DIV=32, BLANK_CYCLES=4, LZ_BLANK=1.
- Reset then idle with count=0:
  - Every frame, seg=000 for 4 cycles of each slot, then 001/010/100 for 28 cycles.
  - Digit 0 codeout=3F; digits 1 and 2 codeout=00.
  - frame_tick period is 96 cycles.
- count=123 applied before frame 0 start: frame 0 shows "0"; frame 1 shows digit 0=4F, digit 1=5B, digit 2=06.
- Leading-zero rule:
  - count=7: digits 1 and 2 codeout=00 with seg asserted; digit 0=07.
  - count=105: digit 1 (tens) codeout=3F.
- Modulo rule: count=1234 displays 4,3,2 (66,4F,5B); count=65535 displays 5,3,5 (6D,4F,6D).
- count changed from 456 to 789 at frame-relative cycle 40:
  - That frame and the next still show 456 (or the old value).
  - 789 appears exactly at the frame start after the next frame-start sample.
- rst_n pulsed low for 2 cycles at slot 1 relative cycle 10 with count=999:
  - seg and codeout drop to 0 asynchronously.
  - After release, the first frame shows "0"; the second frame shows 6F on all three digits.
